// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one variable-latency PMEM port between instruction fetch and load/store with starvation control
module mem_arbiter #(
  parameter logic [63:0] PMEM_BASE    = 64'h8000_0000,
  parameter int          STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req_i,
  input  logic [63:0] if_addr_i,
  output logic        if_ready_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  output logic        if_err_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [2:0]  d_funct3_i,
  input  logic [63:0] d_addr_i,
  input  logic [63:0] d_wdata_i,
  output logic        d_ready_o,
  output logic        d_rvalid_o,
  output logic [63:0] d_rdata_o,
  output logic        d_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  output logic [7:0]  mem_wmask_o,
  input  logic        mem_ack_i,
  input  logic [63:0] mem_rdata_i
);
  localparam int SW = $clog2(STARVE_LIMIT + 2);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic fetch_q, fetch_d;
  logic [2:0] a_q, a_d, f3_q, f3_d;
  logic mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [63:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [7:0] mem_wmask_q, mem_wmask_d;
  logic if_rvalid_q, if_rvalid_d, if_err_q, if_err_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic d_rvalid_q, d_rvalid_d, d_err_q, d_err_d;
  logic [63:0] d_rdata_q, d_rdata_d;
  logic idle, starved, d_bad;
  logic [63:0] gaddr, s, ld;
  logic [7:0] base_mask;
  assign idle       = state_q == IDLE;
  assign starved    = starve_q == SW'(STARVE_LIMIT);
  assign d_ready_o  = idle && d_req_i && !(if_req_i && starved);
  assign if_ready_o = idle && if_req_i && !d_ready_o;
  assign gaddr      = d_ready_o ? d_addr_i : if_addr_i;
  always_comb begin
    d_bad = (d_funct3_i[1:0] == 2'd1) ? d_addr_i[0] :
            (d_funct3_i[1:0] == 2'd2) ? |d_addr_i[1:0] :
            (d_funct3_i[1:0] == 2'd3) ? |d_addr_i[2:0] : 1'b0;
    d_bad = d_bad || (!d_we_i && d_funct3_i == 3'b111);
    base_mask = (d_funct3_i[1:0] == 2'd0) ? 8'h01 :
                (d_funct3_i[1:0] == 2'd1) ? 8'h03 :
                (d_funct3_i[1:0] == 2'd2) ? 8'h0F : 8'hFF;
  end
  always_comb begin
    s = mem_rdata_i >> {a_q, 3'b000};
    case (f3_q)
      3'b000:  ld = {{56{s[7]}}, s[7:0]};
      3'b001:  ld = {{48{s[15]}}, s[15:0]};
      3'b010:  ld = {{32{s[31]}}, s[31:0]};
      3'b011:  ld = s;
      3'b100:  ld = {56'b0, s[7:0]};
      3'b101:  ld = {48'b0, s[15:0]};
      3'b110:  ld = {32'b0, s[31:0]};
      default: ld = '0;
    endcase
  end
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    fetch_d     = fetch_q;
    a_d         = a_q;
    f3_d        = f3_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    if_rvalid_d = 1'b0;
    if_err_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rvalid_d  = 1'b0;
    d_err_d     = 1'b0;
    d_rdata_d   = d_rdata_q;
    if (d_ready_o) begin
      starve_d = if_req_i ? starve_q + SW'(!starved) : '0;
      if (d_bad) begin
        d_rvalid_d = 1'b1;
        d_err_d    = 1'b1;
        d_rdata_d  = '0;
      end else begin
        state_d     = WAIT;
        fetch_d     = 1'b0;
        a_d         = d_addr_i[2:0];
        f3_d        = d_funct3_i;
        mem_req_d   = 1'b1;
        mem_we_d    = d_we_i;
        mem_addr_d  = (gaddr - PMEM_BASE) & ~64'h7;
        mem_wdata_d = d_wdata_i << {d_addr_i[2:0], 3'b000};
        mem_wmask_d = d_we_i ? base_mask << d_addr_i[2:0] : 8'h00;
      end
    end else if (if_ready_o) begin
      starve_d = '0;
      if (|if_addr_i[1:0]) begin
        if_rvalid_d = 1'b1;
        if_err_d    = 1'b1;
        if_rdata_d  = '0;
      end else begin
        state_d     = WAIT;
        fetch_d     = 1'b1;
        a_d         = if_addr_i[2:0];
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b0;
        mem_addr_d  = (gaddr - PMEM_BASE) & ~64'h7;
        mem_wmask_d = 8'h00;
      end
    end else if (!idle && mem_ack_i) begin
      state_d   = IDLE;
      mem_req_d = 1'b0;
      if (fetch_q) begin
        if_rvalid_d = 1'b1;
        if_rdata_d  = a_q[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
      end else begin
        d_rvalid_d = 1'b1;
        d_rdata_d  = mem_we_q ? '0 : ld;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      fetch_q     <= 1'b0;
      a_q         <= '0;
      f3_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      fetch_q     <= fetch_d;
      a_q         <= a_d;
      f3_q        <= f3_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      if_rvalid_q <= if_rvalid_d;
      if_err_q    <= if_err_d;
      if_rdata_q  <= if_rdata_d;
      d_rvalid_q  <= d_rvalid_d;
      d_err_q     <= d_err_d;
      d_rdata_q   <= d_rdata_d;
    end
  end
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wmask_o = mem_wmask_q;
  assign if_rvalid_o = if_rvalid_q;
  assign if_err_o    = if_err_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rvalid_o  = d_rvalid_q;
  assign d_err_o     = d_err_q;
  assign d_rdata_o   = d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus starvation and reset-abort sequences for mem_arbiter
module tb_mem_arbiter;
  logic clock = 1'b0, reset = 1'b1;
  logic if_req_i = 1'b0, d_req_i = 1'b0, d_we_i = 1'b0, mem_ack_i = 1'b0;
  logic [63:0] if_addr_i = '0, d_addr_i = '0, d_wdata_i = '0, mem_rdata_i = '0;
  logic [2:0] d_funct3_i = '0;
  logic if_ready_o, if_rvalid_o, if_err_o, d_ready_o, d_rvalid_o, d_err_o;
  logic mem_req_o, mem_we_o;
  logic [31:0] if_rdata_o;
  logic [63:0] d_rdata_o, mem_addr_o, mem_wdata_o;
  logic [7:0] mem_wmask_o;
  int total = 0, passed = 0;
  mem_arbiter #(.PMEM_BASE(64'h8000_0000), .STARVE_LIMIT(2)) dut (
    .clock(clock), .reset(reset),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ready_o(if_ready_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_funct3_i(d_funct3_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_ready_o(d_ready_o), .d_rvalid_o(d_rvalid_o),
    .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );
  always #5 clock = ~clock;
  typedef struct {
    logic is_if; logic we; logic [2:0] f3; logic [63:0] addr, wdata, mrdata; int k;
    logic err; logic [63:0] maddr; logic [7:0] wmask; logic [63:0] mwdata, rdata;
  } vec_t;
  vec_t vecs[17];
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask
  task automatic run(input vec_t v, input int i);
    int n = 0;
    logic [63:0] held;
    if_req_i = v.is_if; if_addr_i = v.addr;
    d_req_i = !v.is_if; d_we_i = v.we; d_funct3_i = v.f3; d_addr_i = v.addr; d_wdata_i = v.wdata;
    #1;
    while (!(v.is_if ? if_ready_o : d_ready_o) && n < 10) begin tick(); n++; end
    chk($sformatf("v%0d ready", i), v.is_if ? if_ready_o : d_ready_o, 1);
    tick();
    if_req_i = 1'b0; d_req_i = 1'b0;
    if (v.err) begin
      chk($sformatf("v%0d err_no_mem_req", i), mem_req_o, 0);
      chk($sformatf("v%0d err_rvalid", i), v.is_if ? if_rvalid_o : d_rvalid_o, 1);
      chk($sformatf("v%0d err_flag", i), v.is_if ? if_err_o : d_err_o, 1);
      chk($sformatf("v%0d err_rdata", i), v.is_if ? {32'b0, if_rdata_o} : d_rdata_o, 0);
    end else begin
      chk($sformatf("v%0d mem_req", i), mem_req_o, 1);
      chk($sformatf("v%0d mem_addr", i), mem_addr_o, v.maddr);
      chk($sformatf("v%0d mem_wmask", i), mem_wmask_o, v.wmask);
      chk($sformatf("v%0d mem_we", i), mem_we_o, v.we);
      if (v.we) chk($sformatf("v%0d mem_wdata", i), mem_wdata_o, v.mwdata);
      for (int c = 0; c < v.k; c++) begin
        tick();
        chk($sformatf("v%0d wait_hold", i), {mem_req_o, mem_addr_o}, {1'b1, v.maddr});
        chk($sformatf("v%0d early_rvalid", i), v.is_if ? if_rvalid_o : d_rvalid_o, 0);
      end
      mem_ack_i = 1'b1; mem_rdata_i = v.mrdata;
      tick();
      mem_ack_i = 1'b0; mem_rdata_i = 64'h5555_AAAA_5555_AAAA;
      chk($sformatf("v%0d req_clear", i), mem_req_o, 0);
      chk($sformatf("v%0d rvalid", i), v.is_if ? if_rvalid_o : d_rvalid_o, 1);
      chk($sformatf("v%0d err", i), v.is_if ? if_err_o : d_err_o, 0);
      chk($sformatf("v%0d rdata", i), v.is_if ? {32'b0, if_rdata_o} : d_rdata_o, v.rdata);
    end
    held = v.is_if ? {32'b0, if_rdata_o} : d_rdata_o;
    tick();
    chk($sformatf("v%0d rvalid_pulse", i), v.is_if ? if_rvalid_o : d_rvalid_o, 0);
    chk($sformatf("v%0d rdata_hold", i), v.is_if ? {32'b0, if_rdata_o} : d_rdata_o, held);
  endtask
  task automatic grant(input int i, output logic was_d);
    int n = 0;
    while (!d_ready_o && !if_ready_o && n < 20) begin tick(); n++; end
    chk($sformatf("g%0d some_ready", i), d_ready_o | if_ready_o, 1);
    chk($sformatf("g%0d one_ready", i), d_ready_o & if_ready_o, 0);
    was_d = d_ready_o;
    tick();
    chk($sformatf("g%0d wait_no_ready", i), {d_ready_o, if_ready_o}, 0);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
  endtask
  initial begin
    logic g;
    logic [5:0] seq;
    vecs[0]  = '{1, 0, 3'b000, 64'h8000_0004, 0, 64'h1122_3344_5566_7788, 2, 0, 64'h0, 8'h00, 0, 64'h1122_3344};
    vecs[1]  = '{1, 0, 3'b000, 64'h8000_0008, 0, 64'h1122_3344_5566_7788, 0, 0, 64'h8, 8'h00, 0, 64'h5566_7788};
    vecs[2]  = '{0, 0, 3'b000, 64'h8000_0013, 0, 64'h0000_0000_8000_0000, 1, 0, 64'h10, 8'h00, 0, 64'hFFFF_FFFF_FFFF_FF80};
    vecs[3]  = '{0, 0, 3'b100, 64'h8000_0013, 0, 64'h0000_0000_8000_0000, 1, 0, 64'h10, 8'h00, 0, 64'h80};
    vecs[4]  = '{0, 1, 3'b001, 64'h8000_0006, 64'hABCD, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 64'h0, 8'hC0, 64'hABCD_0000_0000_0000, 0};
    vecs[5]  = '{0, 0, 3'b010, 64'h8000_0002, 0, 0, 0, 1, 0, 8'h00, 0, 0};
    vecs[6]  = '{1, 0, 3'b000, 64'h8000_0002, 0, 0, 0, 1, 0, 8'h00, 0, 0};
    vecs[7]  = '{0, 0, 3'b001, 64'h8000_000A, 0, 64'h1122_3344_8001_7788, 0, 0, 64'h8, 8'h00, 0, 64'hFFFF_FFFF_FFFF_8001};
    vecs[8]  = '{0, 0, 3'b110, 64'h8000_0014, 0, 64'hDEAD_BEEF_0000_0001, 3, 0, 64'h10, 8'h00, 0, 64'hDEAD_BEEF};
    vecs[9]  = '{0, 0, 3'b010, 64'h8000_0014, 0, 64'hDEAD_BEEF_0000_0001, 0, 0, 64'h10, 8'h00, 0, 64'hFFFF_FFFF_DEAD_BEEF};
    vecs[10] = '{0, 0, 3'b011, 64'h8000_0020, 0, 64'h0123_4567_89AB_CDEF, 1, 0, 64'h20, 8'h00, 0, 64'h0123_4567_89AB_CDEF};
    vecs[11] = '{0, 1, 3'b011, 64'h8000_0028, 64'hCAFE_BABE_1234_5678, 64'h1, 0, 0, 64'h28, 8'hFF, 64'hCAFE_BABE_1234_5678, 0};
    vecs[12] = '{0, 1, 3'b000, 64'h8000_0031, 64'h5A, 64'h1, 2, 0, 64'h30, 8'h02, 64'h5A00, 0};
    vecs[13] = '{0, 1, 3'b010, 64'h8000_0044, 64'h1234_5678, 64'h1, 0, 0, 64'h40, 8'hF0, 64'h1234_5678_0000_0000, 0};
    vecs[14] = '{0, 0, 3'b111, 64'h8000_0000, 0, 0, 0, 1, 0, 8'h00, 0, 0};
    vecs[15] = '{0, 0, 3'b011, 64'h8000_0004, 0, 0, 0, 1, 0, 8'h00, 0, 0};
    vecs[16] = '{0, 0, 3'b101, 64'h8000_000E, 0, 64'hBEEF_0000_0000_0000, 1, 0, 64'h8, 8'h00, 0, 64'hBEEF};
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst mem_req", mem_req_o, 0);
    chk("rst mem_addr", mem_addr_o, 0);
    chk("rst rvalids", {if_rvalid_o, d_rvalid_o, if_err_o, d_err_o}, 0);
    chk("rst readies", {if_ready_o, d_ready_o}, 0);
    mem_ack_i = 1'b1; mem_rdata_i = 64'hFFFF;
    tick();
    mem_ack_i = 1'b0;
    chk("idle_ack no_rvalid", {if_rvalid_o, d_rvalid_o, mem_req_o}, 0);
    for (int i = 0; i < 17; i++) run(vecs[i], i);
    if_req_i = 1'b1; if_addr_i = 64'h8000_0000;
    d_req_i = 1'b1; d_we_i = 1'b0; d_funct3_i = 3'b011; d_addr_i = 64'h8000_0000;
    #1;
    for (int i = 0; i < 6; i++) begin grant(i, g); seq[5 - i] = g; end
    chk("starve seq", seq, 6'b110110);
    d_we_i = 1'b1; d_addr_i = 64'h8000_0008; d_wdata_i = 64'h1111;
    grant(6, g);
    chk("pre_reset grant", g, 1);
    #1;
    while (!d_ready_o) tick();
    tick();
    if_req_i = 1'b0; d_req_i = 1'b0;
    chk("inflight mem_req", {mem_req_o, mem_we_o, mem_wmask_o}, {1'b1, 1'b1, 8'hFF});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("wait_rst mem_req", mem_req_o, 0);
    chk("wait_rst mem_regs", {mem_we_o, mem_wmask_o, mem_addr_o, mem_wdata_o}, 0);
    chk("wait_rst results", {if_rvalid_o, d_rvalid_o, if_err_o, d_err_o, if_rdata_o, d_rdata_o}, 0);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    chk("late_ack no_rvalid", {if_rvalid_o, d_rvalid_o, mem_req_o}, 0);
    if_req_i = 1'b1; d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 64'h8000_0000;
    #1;
    for (int i = 0; i < 3; i++) begin grant(7 + i, g); seq[2 - i] = g; end
    chk("post_reset seq", seq[2:0], 3'b110);
    if_req_i = 1'b0; d_req_i = 1'b0;
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
